// File: rtl/snake_step_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : game_pkg                                                   |
// | Shared encodings for the snake step controller: directions, the      |
// | reported game state and the internal FSM states.                     |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package game_pkg;

    localparam logic [1:0] c_dir_up    = 2'd0;
    localparam logic [1:0] c_dir_down  = 2'd1;
    localparam logic [1:0] c_dir_left  = 2'd2;
    localparam logic [1:0] c_dir_right = 2'd3;

    localparam logic [1:0] c_gs_idle  = 2'd0;
    localparam logic [1:0] c_gs_run   = 2'd1;
    localparam logic [1:0] c_gs_pause = 2'd2;
    localparam logic [1:0] c_gs_over  = 2'd3;

    localparam int c_st_w = 3;
    typedef logic [c_st_w-1:0] state_t;

    localparam state_t c_st_idle  = 3'd0;
    localparam state_t c_st_clear = 3'd1;
    localparam state_t c_st_run   = 3'd2;
    localparam state_t c_st_step  = 3'd3;
    localparam state_t c_st_pause = 3'd4;
    localparam state_t c_st_over  = 3'd5;

    // Opposite pairs share bit1 and differ in bit0 (UP/DOWN, LEFT/RIGHT).
    function automatic logic [1:0] f_opposite(input logic [1:0] dir);
        return {dir[1], ~dir[0]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/snake_step_ctrl_dir_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : dir_queue                                                  |
// | Two-entry direction FIFO that drops duplicate and reversing keys.    |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module dir_queue
    import game_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key,
    input  logic [1:0] cur_dir,
    input  logic       pop,
    input  logic       flush,
    output logic [1:0] head,
    output logic       empty
);

    logic [1:0] r_q0;
    logic [1:0] r_q1;
    logic [1:0] r_cnt;
    logic       w_key_vld;
    logic [1:0] w_key_dir;
    logic [1:0] w_ref;
    logic       w_push;
    logic       w_pop;

    // key bit index equals the direction code; lowest index wins
    always_comb begin
        w_key_vld = 1'b1;
        w_key_dir = c_dir_up;
        if (key[0])      w_key_dir = c_dir_up;
        else if (key[1]) w_key_dir = c_dir_down;
        else if (key[2]) w_key_dir = c_dir_left;
        else if (key[3]) w_key_dir = c_dir_right;
        else             w_key_vld = 1'b0;
    end

    always_comb begin
        w_ref = cur_dir;
        if (r_cnt == 2'd2)      w_ref = r_q1;
        else if (r_cnt == 2'd1) w_ref = r_q0;
    end

    assign w_push = w_key_vld && (r_cnt != 2'd2) &&
                    (w_key_dir != w_ref) && (w_key_dir != f_opposite(w_ref));
    assign w_pop  = pop && (r_cnt != 2'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q0  <= c_dir_up;
            r_q1  <= c_dir_up;
            r_cnt <= 2'd0;
        end else if (flush) begin
            r_cnt <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_cnt == 2'd0) r_q0 <= w_key_dir;
                    else               r_q1 <= w_key_dir;
                    r_cnt <= r_cnt + 2'd1;
                end
                2'b01: begin
                    r_q0  <= r_q1;
                    r_cnt <= r_cnt - 2'd1;
                end
                // push needs a free slot and pop a filled one, so count is 1 here
                2'b11: begin
                    r_q0 <= w_key_dir;
                end
                default: begin
                end
            endcase
        end
    end

    assign head  = r_q0;
    assign empty = (r_cnt == 2'd0);

endmodule
`default_nettype wire

// File: rtl/snake_step_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : snake_step_ctrl                                            |
// | Game flow FSM, frame-paced step requests, speed scaling and score.   |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module snake_step_ctrl
    import game_pkg::*;
#(
    parameter int FRAMES_INIT    = 12,
    parameter int FRAMES_MIN     = 3,
    parameter int FOOD_PER_LEVEL = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       p_up,
    input  logic       p_down,
    input  logic       p_left,
    input  logic       p_right,
    input  logic       p_start,
    input  logic       vga_vs,
    input  logic       step_done,
    input  logic       hit,
    input  logic       ate,
    output logic       step_req,
    output logic [1:0] step_dir,
    output logic       clear_req,
    output logic [1:0] game_state,
    output logic [3:0] speed_level,
    output logic [7:0] score
);

    localparam logic [7:0] c_frames_init = 8'(FRAMES_INIT);
    localparam logic [7:0] c_frames_min  = 8'(FRAMES_MIN);
    localparam logic [7:0] c_food_last   = 8'(FOOD_PER_LEVEL - 1);

    state_t     r_state;
    state_t     w_next;
    logic       r_vs_hist;
    logic [7:0] r_frame_cnt;
    logic [7:0] r_food_cnt;
    logic [3:0] r_level;
    logic [7:0] r_score;
    logic [1:0] r_dir;
    logic       r_pause_pend;

    logic       w_tick;
    logic [7:0] w_level_ext;
    logic [7:0] w_period;
    logic       w_period_done;
    logic       w_step_go;
    logic       w_enter_clear;
    logic       w_ack_ok;
    logic       w_key_en;
    logic [3:0] w_keys;
    logic [1:0] w_q_head;
    logic       w_q_empty;

    assign w_tick      = r_vs_hist & ~vga_vs;
    assign w_level_ext = {4'd0, r_level};
    assign w_period    = (c_frames_init > (w_level_ext + c_frames_min)) ?
                         (c_frames_init - w_level_ext) : c_frames_min;
    assign w_period_done = w_tick && (r_frame_cnt == (w_period - 8'd1));
    // a start key in RUN wins over a completing tick, preserving the count
    assign w_step_go     = (r_state == c_st_run) && !p_start && w_period_done;
    assign w_enter_clear = p_start && ((r_state == c_st_idle) || (r_state == c_st_over));
    assign w_ack_ok      = (r_state == c_st_step) && step_done && !hit;
    assign w_key_en      = (r_state == c_st_run) || (r_state == c_st_step) ||
                           (r_state == c_st_pause);
    assign w_keys        = w_key_en ? {p_right, p_left, p_down, p_up} : 4'd0;

    dir_queue u_dir_queue (
        .clk     (clk),
        .rst     (rst),
        .key     (w_keys),
        .cur_dir (r_dir),
        .pop     (w_step_go),
        .flush   (w_enter_clear),
        .head    (w_q_head),
        .empty   (w_q_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= c_st_idle;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_st_idle:  if (p_start) w_next = c_st_clear;
            c_st_clear: if (step_done) w_next = c_st_run;
            c_st_run: begin
                if (p_start)            w_next = c_st_pause;
                else if (w_period_done) w_next = c_st_step;
            end
            c_st_step: begin
                if (step_done) begin
                    if (hit)                          w_next = c_st_over;
                    else if (r_pause_pend || p_start) w_next = c_st_pause;
                    else                              w_next = c_st_run;
                end
            end
            c_st_pause: if (p_start) w_next = c_st_run;
            c_st_over:  if (p_start) w_next = c_st_clear;
            default:    w_next = c_st_idle;
        endcase
    end

    always_comb begin
        step_req   = 1'b0;
        clear_req  = 1'b0;
        game_state = c_gs_idle;
        case (r_state)
            c_st_clear: begin
                clear_req  = 1'b1;
                game_state = c_gs_run;
            end
            c_st_run:   game_state = c_gs_run;
            c_st_step: begin
                step_req   = 1'b1;
                game_state = c_gs_run;
            end
            c_st_pause: game_state = c_gs_pause;
            c_st_over:  game_state = c_gs_over;
            default:    game_state = c_gs_idle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vs_hist    <= 1'b1;
            r_frame_cnt  <= 8'd0;
            r_food_cnt   <= 8'd0;
            r_level      <= 4'd0;
            r_score      <= 8'd0;
            r_dir        <= c_dir_right;
            r_pause_pend <= 1'b0;
        end else begin
            r_vs_hist <= vga_vs;
            if (w_enter_clear) begin
                r_frame_cnt  <= 8'd0;
                r_food_cnt   <= 8'd0;
                r_level      <= 4'd0;
                r_score      <= 8'd0;
                r_dir        <= c_dir_right;
                r_pause_pend <= 1'b0;
            end else begin
                if ((r_state == c_st_run) && !p_start && w_tick)
                    r_frame_cnt <= w_period_done ? 8'd0 : (r_frame_cnt + 8'd1);

                // direction changes on the edge that raises step_req
                if (w_step_go && !w_q_empty)
                    r_dir <= w_q_head;

                if (r_state == c_st_step) begin
                    if (step_done)    r_pause_pend <= 1'b0;
                    else if (p_start) r_pause_pend <= 1'b1;
                end

                if (w_ack_ok && ate) begin
                    if (r_score != 8'hFF) r_score <= r_score + 8'd1;
                    if (r_food_cnt == c_food_last) begin
                        r_food_cnt <= 8'd0;
                        if (w_period > c_frames_min) r_level <= r_level + 4'd1;
                    end else begin
                        r_food_cnt <= r_food_cnt + 8'd1;
                    end
                end
            end
        end
    end

    assign step_dir    = r_dir;
    assign speed_level = r_level;
    assign score       = r_score;

endmodule
`default_nettype wire

// File: tb/tb_snake_step_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_snake_step_ctrl                                         |
// | Directed self-checking bench with an expected-direction scoreboard.  |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_snake_step_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       p_up = 1'b0, p_down = 1'b0, p_left = 1'b0, p_right = 1'b0;
    logic       p_start = 1'b0;
    logic       vga_vs = 1'b1;
    logic       step_done = 1'b0, hit = 1'b0, ate = 1'b0;
    logic       step_req, clear_req;
    logic [1:0] step_dir, game_state;
    logic [3:0] speed_level;
    logic [7:0] score;

    int n_cmp = 0;
    int n_err = 0;

    logic [1:0] exp_dir_q[$];
    logic [1:0] m_dir = 2'd3;
    int         m_state = 0;
    int         m_score = 0;
    int         m_level = 0;
    int         m_food  = 0;

    snake_step_ctrl #(
        .FRAMES_INIT    (12),
        .FRAMES_MIN     (3),
        .FOOD_PER_LEVEL (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .p_up        (p_up),
        .p_down      (p_down),
        .p_left      (p_left),
        .p_right     (p_right),
        .p_start     (p_start),
        .vga_vs      (vga_vs),
        .step_done   (step_done),
        .hit         (hit),
        .ate         (ate),
        .step_req    (step_req),
        .step_dir    (step_dir),
        .clear_req   (clear_req),
        .game_state  (game_state),
        .speed_level (speed_level),
        .score       (score)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic frame();
        vga_vs = 1'b0;
        cyc();
        vga_vs = 1'b1;
        cyc();
    endtask

    task automatic press(input logic [4:0] k);
        {p_start, p_right, p_left, p_down, p_up} = k;
        cyc();
        {p_start, p_right, p_left, p_down, p_up} = 5'd0;
    endtask

    function automatic int mperiod();
        return (12 - m_level > 3) ? (12 - m_level) : 3;
    endfunction

    // pmode: 0 plain ack, 1 start key while requesting, 2 start key with the ack
    task automatic run_step(input int frames, input logic a, input logic h, input int pmode);
        for (int i = 0; i < frames - 1; i++) frame();
        if (frames > 1) check("step_req_early", step_req, 0);
        frame();
        check("step_req", step_req, 1);
        if (exp_dir_q.size() > 0) m_dir = exp_dir_q.pop_front();
        check("step_dir", step_dir, m_dir);
        if (pmode == 1) begin
            press(5'b10000);
            check("stay_step", step_req, 1);
        end
        step_done = 1'b1;
        ate = a;
        hit = h;
        if (pmode == 2) p_start = 1'b1;
        cyc();
        step_done = 1'b0;
        ate = 1'b0;
        hit = 1'b0;
        p_start = 1'b0;
        check("step_req_drop", step_req, 0);
        if (h) begin
            m_state = 3;
        end else begin
            if (a) begin
                if (m_score < 255) m_score++;
                m_food++;
                if (m_food == 4) begin
                    m_food = 0;
                    if (mperiod() > 3) m_level++;
                end
            end
            m_state = (pmode != 0) ? 2 : 1;
        end
        check("game_state", game_state, 8'(m_state));
        check("score", score, 8'(m_score));
        check("speed_level", speed_level, 8'(m_level));
    endtask

    initial begin
        // reset values
        repeat (3) cyc();
        check("rst_step_req", step_req, 0);
        check("rst_clear_req", clear_req, 0);
        check("rst_step_dir", step_dir, 3);
        check("rst_game_state", game_state, 0);
        check("rst_speed", speed_level, 0);
        check("rst_score", score, 0);
        rst = 1'b1;
        cyc();

        // start a game and clear the board
        press(5'b10000);
        check("clear_req_on", clear_req, 1);
        check("clear_state", game_state, 1);
        press(5'b10000);
        check("clear_start_ignored", clear_req, 1);
        step_done = 1'b1;
        cyc();
        step_done = 1'b0;
        check("clear_req_off", clear_req, 0);
        check("run_state", game_state, 1);

        run_step(12, 1'b0, 1'b0, 0);

        // ack outside STEP must not score
        step_done = 1'b1;
        ate = 1'b1;
        cyc();
        step_done = 1'b0;
        ate = 1'b0;
        check("stray_ack_score", score, 0);
        check("stray_ack_state", game_state, 1);

        // direction queue: reversal rejected, two accepted, third dropped
        press(5'b00100);
        press(5'b00001);
        exp_dir_q.push_back(2'd0);
        press(5'b00100);
        exp_dir_q.push_back(2'd2);
        press(5'b00010);
        run_step(12, 1'b0, 1'b0, 0);
        run_step(12, 1'b0, 1'b0, 0);
        // simultaneous up and down while heading LEFT: up has priority
        press(5'b00011);
        exp_dir_q.push_back(2'd0);
        run_step(12, 1'b0, 1'b0, 0);

        // eat until the speed saturates, then a few more
        for (int k = 0; k < 60 && m_level < 9; k++) run_step(mperiod(), 1'b1, 1'b0, 0);
        check("level_sat", speed_level, 9);
        for (int k = 0; k < 4; k++) run_step(mperiod(), 1'b1, 1'b0, 0);
        check("level_hold", speed_level, 9);
        check("score_40", score, 40);

        // pause in RUN keeps the partial frame count
        frame();
        press(5'b10000);
        check("pause_state", game_state, 2);
        repeat (6) frame();
        check("pause_no_step", step_req, 0);
        press(5'b10000);
        check("resume_state", game_state, 1);
        run_step(2, 1'b0, 1'b0, 0);

        // pause requested during a step, then with the ack itself
        run_step(3, 1'b0, 1'b0, 1);
        repeat (4) frame();
        check("pause_step_hold", step_req, 0);
        press(5'b10000);
        run_step(3, 1'b0, 1'b0, 2);
        press(5'b00100);
        exp_dir_q.push_back(2'd2);
        press(5'b10000);
        run_step(3, 1'b0, 1'b0, 0);

        // hit together with ate: game over, score unchanged
        run_step(3, 1'b1, 1'b1, 0);
        check("over_score", score, 40);
        press(5'b10000);
        m_score = 0;
        m_level = 0;
        m_food  = 0;
        m_dir   = 2'd3;
        check("restart_clear", clear_req, 1);
        check("restart_score", score, 0);
        check("restart_level", speed_level, 0);
        check("restart_dir", step_dir, 3);
        step_done = 1'b1;
        cyc();
        step_done = 1'b0;
        check("restart_run", game_state, 1);

        // reset in the middle of a step handshake
        repeat (12) frame();
        check("pre_rst_step_req", step_req, 1);
        rst = 1'b0;
        #1;
        check("mid_rst_step_req", step_req, 0);
        check("mid_rst_state", game_state, 0);
        check("mid_rst_dir", step_dir, 3);
        cyc();
        rst = 1'b1;
        cyc();
        step_done = 1'b1;
        cyc();
        step_done = 1'b0;
        check("late_ack_step_req", step_req, 0);
        check("late_ack_clear_req", clear_req, 0);
        check("late_ack_state", game_state, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
